// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   - STATE_W and state_t : 2-bit FSM state encoding (IDLE/RUN/PAUSED)
//   - presc_width()       : width of the divide counter, max(1, clog2(div))
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  // Smallest width w with 2**w >= div, never less than one bit.
  function automatic int presc_width(input int div);
    int w;
    w = 0;
    while ((1 << w) < div) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// tick_prescaler
// Divides qualified ticks by DIV and produces a terminal strobe.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   clr  in  synchronous clear of the divide counter
//   en   in  qualified tick, advances the counter
//   term out one-cycle strobe (combinational) on the tick that wraps the counter
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_reg;

  // With DIV=1 LAST is 0, so the counter never leaves 0 and every
  // enabled tick is terminal.
  assign term = en && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Start/pause/stop controller for a tick-driven stopwatch. Gates the input
// tick through a run/pause FSM, divides it by DIV, and keeps an elapsed
// count with lap capture and wrap/saturate overflow.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   pulse      in   one-cycle tick strobe
//   start      in   start/resume request
//   pause      in   pause request
//   stop       in   stop and clear request
//   lap        in   lap capture request
//   pulse_out  out  registered divided tick
//   count      out  elapsed counted ticks
//   lap_count  out  count captured at the last lap
//   lap_valid  out  one-cycle strobe when lap_count updates
//   overflow   out  sticky overflow flag
//   state      out  current FSM state
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV      = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               lap,
  output logic               pulse_out,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   lap_count,
  output logic               lap_valid,
  output logic               overflow,
  output logic [STATE_W-1:0] state
);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] lap_count_reg;
  logic             lap_valid_reg;
  logic             overflow_reg;
  logic             pulse_out_reg;

  logic qual;
  logic tick;

  // Pulses outside RUN, or coinciding with pause/stop, are dropped.
  assign qual = pulse && (state_reg == RUN) && !pause && !stop;

  tick_prescaler #(
    .DIV(DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (stop),
    .en  (qual),
    .term(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      lap_count_reg <= '0;
      lap_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      pulse_out_reg <= 1'b0;
    end else begin
      pulse_out_reg <= tick;

      // Lap sees the count from before this edge, including when a counted
      // tick or a stop lands on the same edge.
      lap_valid_reg <= 1'b0;
      if (lap && (state_reg == RUN || state_reg == PAUSED)) begin
        lap_count_reg <= count_reg;
        lap_valid_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (stop) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
          end else if (start && !pause) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
          end else if (pause) begin
            state_reg <= PAUSED;
          end else if (tick) begin
            if (count_reg == '1) begin
              overflow_reg <= 1'b1;
              if (!SATURATE) count_reg <= '0;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        PAUSED: begin
          if (stop) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
          end else if (start && !pause) begin
            state_reg <= RUN;
          end
        end
        default: begin
          // Illegal encoding: recover to IDLE, count untouched.
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign pulse_out = pulse_out_reg;
  assign count     = count_reg;
  assign lap_count = lap_count_reg;
  assign lap_valid = lap_valid_reg;
  assign overflow  = overflow_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: four parameterisations driven by shared
// stimulus, each compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0, lap = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance parameters: A(16,1,wrap) B(16,3,wrap) C(4,1,wrap) D(4,1,sat)
  int p_w[NI]   = '{16, 16, 4, 4};
  int p_div[NI] = '{1, 3, 1, 1};
  int p_sat[NI] = '{0, 0, 0, 1};

  logic [NI-1:0] po, lv, ov;
  logic [1:0]  st_a, st_b, st_c, st_d;
  logic [15:0] cnt_a, lc_a, cnt_b, lc_b;
  logic [3:0]  cnt_c, lc_c, cnt_d, lc_d;

  stopwatch_ctrl #(.CNT_W(16), .DIV(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .pulse(pulse), .start(start), .pause(pause), .stop(stop), .lap(lap),
    .pulse_out(po[0]), .count(cnt_a), .lap_count(lc_a), .lap_valid(lv[0]), .overflow(ov[0]), .state(st_a));
  stopwatch_ctrl #(.CNT_W(16), .DIV(3), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .pulse(pulse), .start(start), .pause(pause), .stop(stop), .lap(lap),
    .pulse_out(po[1]), .count(cnt_b), .lap_count(lc_b), .lap_valid(lv[1]), .overflow(ov[1]), .state(st_b));
  stopwatch_ctrl #(.CNT_W(4), .DIV(1), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .pulse(pulse), .start(start), .pause(pause), .stop(stop), .lap(lap),
    .pulse_out(po[2]), .count(cnt_c), .lap_count(lc_c), .lap_valid(lv[2]), .overflow(ov[2]), .state(st_c));
  stopwatch_ctrl #(.CNT_W(4), .DIV(1), .SATURATE(1'b1)) u_d (
    .clk(clk), .rst(rst), .pulse(pulse), .start(start), .pause(pause), .stop(stop), .lap(lap),
    .pulse_out(po[3]), .count(cnt_d), .lap_count(lc_d), .lap_valid(lv[3]), .overflow(ov[3]), .state(st_d));

  logic [31:0] d_count[NI], d_lap[NI], d_state[NI];
  always_comb begin
    d_count[0] = {16'b0, cnt_a}; d_lap[0] = {16'b0, lc_a}; d_state[0] = {30'b0, st_a};
    d_count[1] = {16'b0, cnt_b}; d_lap[1] = {16'b0, lc_b}; d_state[1] = {30'b0, st_b};
    d_count[2] = {28'b0, cnt_c}; d_lap[2] = {28'b0, lc_c}; d_state[2] = {30'b0, st_c};
    d_count[3] = {28'b0, cnt_d}; d_lap[3] = {28'b0, lc_d}; d_state[3] = {30'b0, st_d};
  end

  // Model: mode 0=idle 1=run 2=paused (values match the documented state codes)
  int m_mode[NI], m_cnt[NI], m_pre[NI], m_ov[NI], m_lap[NI], m_lv[NI], m_po[NI];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_ov[i] = 0;
      m_lap[i] = 0; m_lv[i] = 0; m_po[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int maxv;
      maxv = (1 << p_w[i]) - 1;
      m_lv[i] = 0;
      m_po[i] = 0;
      if (lap && m_mode[i] != 0) begin
        m_lap[i] = m_cnt[i];
        m_lv[i] = 1;
      end
      if (stop) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_ov[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (pause) m_mode[i] = 2;
        else if (pulse) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == p_div[i]) begin
            m_pre[i] = 0;
            m_po[i] = 1;
            if (m_cnt[i] == maxv) begin
              m_ov[i] = 1;
              m_cnt[i] = p_sat[i] ? maxv : 0;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
      end else if (start && !pause) begin
        m_mode[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("count%0d", i), d_count[i], 32'(m_cnt[i]));
      check($sformatf("lap_count%0d", i), d_lap[i], 32'(m_lap[i]));
      check($sformatf("state%0d", i), d_state[i], 32'(m_mode[i]));
      check($sformatf("pulse_out%0d", i), 32'(po[i]), 32'(m_po[i]));
      check($sformatf("lap_valid%0d", i), 32'(lv[i]), 32'(m_lv[i]));
      check($sformatf("overflow%0d", i), 32'(ov[i]), 32'(m_ov[i]));
    end
  endtask

  task automatic cycle(input logic p, input logic s, input logic pa, input logic sp, input logic l);
    @(negedge clk);
    pulse = p; start = s; pause = pa; stop = sp; lap = l;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Start with a coincident pulse: the pulse must be dropped.
    cycle(1, 1, 0, 0, 0);
    repeat (5) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    check("run_state", d_state[0], 32'd1);
    check("count_after5", d_count[0], 32'd5);

    repeat (12) cycle(1, 0, 0, 0, 0);
    check("wrap_count", d_count[2], 32'd1);
    check("wrap_ovf", 32'(ov[2]), 32'd1);
    check("sat_count", d_count[3], 32'd15);
    check("sat_ovf", 32'(ov[3]), 32'd1);
    check("div3_count", d_count[1], 32'd5);

    // Lap on the same edge as a counted tick captures the old count.
    cycle(1, 0, 0, 0, 1);
    check("lap_pre_inc", d_lap[0], 32'd17);
    check("count_post_lap", d_count[0], 32'd18);
    cycle(0, 0, 0, 0, 0);
    check("lap_strobe_end", 32'(lv[0]), 32'd0);

    // Pause, drop pulses, pause+start stays paused, then resume.
    cycle(0, 0, 1, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check("paused_hold", d_state[0], 32'd2);
    cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);

    // stop+pause+start+lap in RUN: idle and cleared, lap takes pre-clear value.
    cycle(0, 1, 1, 1, 1);
    check("stop_state", d_state[0], 32'd0);
    check("stop_count", d_count[0], 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("idle_lap_ignored", 32'(lv[0]), 32'd0);

    // Randomised phase.
    for (int n = 0; n < 600; n++) begin
      cycle(logic'($urandom_range(99) < 55), logic'($urandom_range(99) < 20),
            logic'($urandom_range(99) < 8), logic'($urandom_range(99) < 3),
            logic'($urandom_range(99) < 10));
    end

    // Asynchronous reset mid-run, checked before the next clock edge.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (12) cycle(1, 0, 0, 0, 0);
    check("pre_reset_count", d_count[0], 32'd12);
    @(negedge clk);
    pulse = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; lap = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
